// File: rtl/seq_player_pkg.sv
// Shared types and constants for the digit sequence player (SEQ_PLAYER_GAP_EN adds the GAP state).
// No logic of its own; helpers are pure combinational functions.
// No flow control; constants only.
package seq_player_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int LED_W      = 10;
    localparam int SEQ_W      = NUM_DIGITS * DIGIT_W;

    localparam logic [DIGIT_W-1:0] BLANK_DIGIT = 4'hF;
    localparam logic [LED_W-1:0]   LED_OFF     = 10'h000;

`ifdef SEQ_PLAYER_GAP_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHOW   = 2'd1,
        ST_GAP    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHOW   = 2'd1,
        ST_FINISH = 2'd3
    } state_t;
`endif

    // Values 10..15 have no LED and display as blank.
    function automatic logic [LED_W-1:0] digit_onehot(input logic [DIGIT_W-1:0] d);
        logic [LED_W-1:0] r;
        r = LED_OFF;
        if (d <= 4'd9)
            r = LED_W'(1) << d;
        return r;
    endfunction

    function automatic logic [2:0] clamp_len(input logic [2:0] n);
        return (n > 3'(NUM_DIGITS)) ? 3'(NUM_DIGITS) : n;
    endfunction

endpackage

// File: rtl/seq_dwell_timer.sv
// Dwell timer: load N, expire pulses during the Nth cycle after the load edge; clear stops it.
// Latency: expire asserts N cycles after load is sampled (N=1 -> the very next cycle).
// No backpressure; load wins over a running count, counter saturates at zero.
module seq_dwell_timer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic        expire
);

    logic [31:0] cnt_q;
    logic        run_q;

    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            cnt_q <= 32'd0;
            run_q <= 1'b0;
        end else if (load) begin
            cnt_q <= load_val - 32'd1;
            run_q <= 1'b1;
        end else if (run_q) begin
            if (cnt_q != 32'd0)
                cnt_q <= cnt_q - 32'd1;
            else
                run_q <= 1'b0;
        end
    end

    assign expire = run_q && (cnt_q == 32'd0);

endmodule

// File: rtl/seq_player.sv
// Plays up to four latched digits on a one-hot LED bar; SEQ_PLAYER_GAP_EN inserts blank gaps.
// Latency: first LED update one cycle after START; DONE/BUSY decode straight from the state register.
// No backpressure: START outside IDLE is dropped, ABORT/RESET cut playback immediately.
module seq_player
    import seq_player_pkg::*;
#(
    parameter logic [31:0] DIGIT_CYCLES = 32'd25000000,
    parameter logic [31:0] GAP_CYCLES   = 32'd5000000
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic               ABORT,
    input  logic [SEQ_W-1:0]   SEQUENCE,
    input  logic [2:0]         SEQUENCE_BIT,
    output logic [LED_W-1:0]   LED,
    output logic [2:0]         DIGIT_IDX,
    output logic [DIGIT_W-1:0] DIGIT_VAL,
    output logic               BUSY,
    output logic               DONE,
    output logic               BAD_DIGIT
);

    state_t               state_q, state_nxt;
    logic [SEQ_W-1:0]     seq_q, seq_nxt, show_seq;
    logic [2:0]           len_q, len_nxt;
    logic [2:0]           idx_q, idx_nxt, show_idx;
    logic [DIGIT_W-1:0]   val_q, val_nxt, show_val;
    logic [LED_W-1:0]     led_q, led_nxt;
    logic                 bad_q, bad_nxt;
    logic                 start_acc, last_digit;
    logic                 tmr_load, tmr_clear, tmr_expire, load_gap;
    logic [31:0]          tmr_load_val;

    assign start_acc  = (state_q == ST_IDLE) && START && !ABORT;
    assign last_digit = (idx_q == (len_q - 3'd1));

    always_ff @(posedge CLK) begin
        if (RESET)
            state_q <= ST_IDLE;
        else
            state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:
                if (start_acc)
                    state_nxt = (clamp_len(SEQUENCE_BIT) == 3'd0) ? ST_FINISH : ST_SHOW;
            ST_SHOW:
                if (tmr_expire) begin
                    if (last_digit)
                        state_nxt = ST_FINISH;
                    else
`ifdef SEQ_PLAYER_GAP_EN
                        state_nxt = ST_GAP;
`else
                        state_nxt = ST_SHOW;
`endif
                end
`ifdef SEQ_PLAYER_GAP_EN
            ST_GAP:
                if (tmr_expire)
                    state_nxt = ST_SHOW;
`endif
            ST_FINISH:
                state_nxt = ST_IDLE;
            default:
                state_nxt = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && ABORT)
            state_nxt = ST_IDLE;
    end

    // Next values of the registered display outputs and timer control.
    always_comb begin
        seq_nxt   = seq_q;
        len_nxt   = len_q;
        idx_nxt   = idx_q;
        val_nxt   = val_q;
        led_nxt   = led_q;
        bad_nxt   = bad_q;
        tmr_load  = 1'b0;
        tmr_clear = 1'b0;
        load_gap  = 1'b0;
        show_seq  = seq_q;
        show_idx  = idx_q + 3'd1;
        if (start_acc) begin
            seq_nxt  = SEQUENCE;
            len_nxt  = clamp_len(SEQUENCE_BIT);
            idx_nxt  = 3'd0;
            bad_nxt  = 1'b0;
            show_seq = SEQUENCE;
            show_idx = 3'd0;
        end
        show_val = show_seq[{show_idx[1:0], 2'b00} +: DIGIT_W];

        if (state_nxt == ST_SHOW && (state_q != ST_SHOW || tmr_expire)) begin
            idx_nxt  = show_idx;
            val_nxt  = show_val;
            led_nxt  = digit_onehot(show_val);
            bad_nxt  = bad_nxt | (show_val > 4'd9);
            tmr_load = 1'b1;
        end else if (state_nxt != ST_SHOW) begin
            led_nxt = LED_OFF;
`ifdef SEQ_PLAYER_GAP_EN
            if (state_nxt == ST_GAP && state_q == ST_SHOW) begin
                tmr_load = 1'b1;
                load_gap = 1'b1;
            end
`endif
            if (state_nxt == ST_IDLE || state_nxt == ST_FINISH)
                tmr_clear = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            seq_q <= {SEQ_W{1'b1}};
            len_q <= 3'd0;
            idx_q <= 3'd0;
            val_q <= BLANK_DIGIT;
            led_q <= LED_OFF;
            bad_q <= 1'b0;
        end else begin
            seq_q <= seq_nxt;
            len_q <= len_nxt;
            idx_q <= idx_nxt;
            val_q <= val_nxt;
            led_q <= led_nxt;
            bad_q <= bad_nxt;
        end
    end

    // load_gap is tied low when the gap feature is compiled out.
    assign tmr_load_val = load_gap ? GAP_CYCLES : DIGIT_CYCLES;

    seq_dwell_timer u_timer (
        .CLK      (CLK),
        .RESET    (RESET),
        .clear    (tmr_clear),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .expire   (tmr_expire)
    );

    assign LED       = led_q;
    assign DIGIT_IDX = idx_q;
    assign DIGIT_VAL = val_q;
    assign BAD_DIGIT = bad_q;
    assign BUSY      = (state_q != ST_IDLE);
    assign DONE      = (state_q == ST_FINISH);

endmodule
